// File: rtl/uart_pkg.sv
// Shared UART baud-generator definitions: supported baud rates, default
// configuration constants and the divisor calculation used for reset values.
package uart_pkg;

    typedef enum logic [2:0] {
        BAUD_9600,
        BAUD_19200,
        BAUD_38400,
        BAUD_57600,
        BAUD_115200,
        BAUD_230400,
        BAUD_460800,
        BAUD_921600
    } baud_e;

    localparam int unsigned DEF_CLK_HZ = 100_000_000;
    localparam int unsigned DEF_OSR    = 16;
    localparam int unsigned MIN_DIV    = 2;
    localparam baud_e       DEF_BAUD   = BAUD_115200;

    typedef struct packed {
        logic [31:0] div;
        logic [31:0] frac;
    } div_cfg_t;

    function automatic int unsigned baud_hz(input baud_e b);
        case (b)
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            BAUD_38400:  return 38400;
            BAUD_57600:  return 57600;
            BAUD_115200: return 115200;
            BAUD_230400: return 230400;
            BAUD_460800: return 460800;
            BAUD_921600: return 921600;
            default:     return 115200;
        endcase
    endfunction

    // Cycles per oversample tick as fixed point div.frac, rounded to nearest.
    function automatic div_cfg_t calc_div(input int unsigned clk_hz,
                                          input int unsigned baud,
                                          input int unsigned osr,
                                          input int unsigned frac_w);
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] q;
        div_cfg_t    r;
        num    = 64'(clk_hz) << (frac_w + 1);
        den    = 64'(baud) * 64'(osr);
        q      = ((num / den) + 64'd1) >> 1;
        r.div  = 32'(q >> frac_w);
        r.frac = 32'(q & ((64'd1 << frac_w) - 64'd1));
        return r;
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Base tick counter with optional fractional accumulator.
// With UART_BAUD_FRAC_EN defined, each period is div_act cycles plus one
// whenever the accumulator carries; otherwise every period is div_act cycles.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W  = 20,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_act,
    input  logic [FRAC_W-1:0] frac_act,
    input  logic              acc_clr,
    output logic              tick_nxt,
    output logic              wrap,
    output logic              tick
);

    localparam logic [DIV_W:0] ONE = (DIV_W + 1)'(1);
    localparam logic [DIV_W:0] TWO = (DIV_W + 1)'(MIN_DIV);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W:0]   period;
    logic             carry;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;

    // The carry of acc+frac lengthens the period currently being counted.
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, frac_act};
        carry   = acc_sum[FRAC_W];
    end

    // Accumulator advances once per period; cleared when a new divisor lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (!en)
            acc <= '0;
        else if (wrap)
            acc <= acc_clr ? '0 : acc_sum[FRAC_W-1:0];
    end
`else
    logic unused_cfg;

    // Fractional path absent: fixed integer period.
    always_comb begin
        carry      = 1'b0;
        unused_cfg = ^{frac_act, acc_clr};
    end
`endif

    // Period length and the two decode points derived from the counter.
    always_comb begin
        period   = {1'b0, div_act} + {{DIV_W{1'b0}}, carry};
        wrap     = en && ({1'b0, cnt} == period - ONE);
        tick_nxt = en && ({1'b0, cnt} == period - TWO);
    end

    // Base counter 0..period-1, held at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en || wrap)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Registered tick, high in the cycle the counter sits at period-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick <= 1'b0;
        else
            tick <= tick_nxt;
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator top: divisor shadow/apply logic, tx and rx phase
// counters. Optional fractional divisor enabled by macro UART_BAUD_FRAC_EN.
// Inputs are sampled on the clock edge, so rx_resync_i counts as coincident
// with a tick when sampled at the edge on which rx_tick_o rises.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned OSR    = DEF_OSR,
    parameter int unsigned DIV_W  = 20,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [FRAC_W-1:0] frac_i,
    input  logic              load_i,
    input  logic              rx_resync_i,
    output logic              rx_tick_o,
    output logic              rx_mid_o,
    output logic              tx_tick_o,
    output logic              cfg_err_o
);

    localparam div_cfg_t         DEF_CFG   = calc_div(CLK_HZ, baud_hz(DEF_BAUD), OSR, FRAC_W);
    localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(DEF_CFG.div);
    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam int unsigned      PH_W      = $clog2(OSR);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0]  PH_MID    = PH_W'(OSR / 2 - 1);

    logic [DIV_W-1:0]  div_act;
    logic [DIV_W-1:0]  sh_div;
    logic [FRAC_W-1:0] frac_act;
    logic              pending;
    logic              apply;
    logic              wrap;
    logic              tick_nxt;
    logic [PH_W-1:0]   tx_phase;
    logic [PH_W-1:0]   rx_phase;

    // Shadow lands at a period boundary, or straight away when idle.
    always_comb apply = pending && (!en_i || wrap);

    // Integer divisor shadow, apply and illegal-divisor flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_act   <= DEF_DIV;
            sh_div    <= DEF_DIV;
            pending   <= 1'b0;
            cfg_err_o <= 1'b0;
        end else begin
            if (apply)
                div_act <= sh_div;
            if (load_i) begin
                sh_div    <= (div_i < MIN_DIV_V) ? MIN_DIV_V : div_i;
                cfg_err_o <= (div_i < MIN_DIV_V);
                pending   <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef UART_BAUD_FRAC_EN
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_CFG.frac);

    logic [FRAC_W-1:0] sh_frac;

    // Fractional divisor shadow, applied alongside the integer part.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frac_act <= DEF_FRAC;
            sh_frac  <= DEF_FRAC;
        end else begin
            if (apply)
                frac_act <= sh_frac;
            if (load_i)
                sh_frac <= frac_i;
        end
    end
`else
    logic unused_frac;

    // No fractional support: frac_i is ignored.
    always_comb begin
        frac_act    = '0;
        unused_frac = ^frac_i;
    end
`endif

    uart_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk      (clk_i),
        .rst      (rst_i),
        .en       (en_i),
        .div_act  (div_act),
        .frac_act (frac_act),
        .acc_clr  (apply),
        .tick_nxt (tick_nxt),
        .wrap     (wrap),
        .tick     (rx_tick_o)
    );

    // Phase counters hold the phase of the upcoming tick and step on the
    // edge that raises rx_tick_o, so tx/mid pulses align with that tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_phase  <= '0;
            rx_phase  <= '0;
            tx_tick_o <= 1'b0;
            rx_mid_o  <= 1'b0;
        end else if (!en_i) begin
            tx_phase  <= '0;
            rx_phase  <= '0;
            tx_tick_o <= 1'b0;
            rx_mid_o  <= 1'b0;
        end else begin
            tx_tick_o <= tick_nxt && (tx_phase == PH_LAST);
            rx_mid_o  <= tick_nxt && !rx_resync_i && (rx_phase == PH_MID);
            if (tick_nxt)
                tx_phase <= (tx_phase == PH_LAST) ? '0 : tx_phase + 1'b1;
            if (rx_resync_i)
                rx_phase <= '0;
            else if (tick_nxt)
                rx_phase <= (rx_phase == PH_LAST) ? '0 : rx_phase + 1'b1;
        end
    end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter OSR, default 16, meaning rx oversample ticks per bit (even, 4..32).
REQ-003 SHALL have parameter DIV_W, default 20, meaning width of integer divisor.
REQ-004 SHALL have parameter FRAC_W, default 4, meaning width of fractional divisor.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port en_i, input, 1, generator enable.
REQ-008 SHALL have port div_i, input, DIV_W, integer clk cycles per rx oversample tick.
REQ-009 SHALL have port frac_i, input, FRAC_W, fractional cycles per tick in units of 2^-FRAC_W.
REQ-010 SHALL have port load_i, input, 1, single-cycle pulse committing div_i/frac_i.
REQ-011 SHALL have port rx_resync_i, input, 1, pulse on start-bit edge to restart rx phase.
REQ-012 SHALL have port rx_tick_o, output, 1, single-cycle pulse at baud*OSR.
REQ-013 SHALL have port rx_mid_o, output, 1, single-cycle pulse at bit-centre sample point.
REQ-014 SHALL have port tx_tick_o, output, 1, single-cycle pulse at baud rate.
REQ-015 SHALL have port cfg_err_o, output, 1, sticky illegal-divisor flag.

Function
REQ-016 SHALL run base counter 0..P-1, P = div_act (+1 on fractional carry), asserting rx_tick_o in cycle count==P-1, then wrapping to 0.
REQ-017 SHALL, at each base wrap, add frac_act to FRAC_W-bit accumulator; carry-out extends the next period by one cycle.
REQ-018 SHALL run tx phase counter 0..OSR-1 on rx_tick_o; tx_tick_o asserted in the same cycle as the rx_tick_o where tx phase==OSR-1.
REQ-019 SHALL run rx phase counter 0..OSR-1 on rx_tick_o; rx_mid_o asserted with rx_tick_o where rx phase==OSR/2-1.
REQ-020 SHALL clear only the rx phase counter on rx_resync_i; base, accumulator, tx phase unaffected.
REQ-021 SHALL give rx_resync_i priority over a coincident tick: rx phase=0, no rx_mid_o that cycle.
REQ-022 SHALL capture div_i/frac_i to shadow on load_i; apply at next base wrap (glitch-free), or next cycle if en_i low; accumulator cleared on apply.
REQ-023 SHALL clamp loaded div_i<2 to 2 and set cfg_err_o; cleared by next load with div_i>=2.
REQ-024 SHALL, while en_i low, hold all counters and accumulator at 0 and all tick outputs low; first rx_tick_o P cycles after en_i rises.
REQ-025 SHALL honour load_i and rx_resync_i in the same cycle independently.
REQ-026 SHALL have outputs registered; no combinational path from inputs to outputs.

Reset
REQ-027 SHALL on rst_i clear counters, accumulator, all outputs to 0, and set div_act/frac_act to package defaults for 115200 baud (54/4 at 100 MHz, OSR 16).
REQ-028 SHALL abort a pending shadow load on reset.

Configuration
REQ-029 SHALL support macro UART_BAUD_FRAC_EN: defined -> fractional accumulator per REQ-017; undefined -> frac_i ignored, accumulator absent, P == div_act always.

Structure
REQ-030 SHALL place baud-rate enum, default-divisor function (CLK_HZ, baud, OSR -> div/frac) and constants in shared package uart_pkg.
REQ-031 SHALL implement base counter + accumulator as sub-module uart_frac_div; phase counters in top.

Verification
REQ-032 Reset, en_i=1, defaults, macro on -> rx_tick_o periods 54,54,54,55 repeating; tx_tick_o every 16 rx ticks (~868.0 cycles avg).
REQ-033 load_i div_i=325 frac_i=0 mid-period -> old period completes, then rx_tick_o every 325 cycles; cfg_err_o stays 0.
REQ-034 load_i div_i=1 -> period 2, cfg_err_o=1; then load div_i=10 -> cfg_err_o=0, period 10.
REQ-035 rx_resync_i pulse -> rx_mid_o on the 8th following rx_tick_o; tx_tick_o spacing unchanged.
REQ-036 rx_resync_i coincident with rx_tick_o at rx phase 7 -> no rx_mid_o that cycle, next rx_mid_o 8 ticks later.
REQ-037 rst_i asserted mid-period, mid-load -> outputs 0 immediately (async), after release defaults restored, pending load discarded.
